// File: rtl/byte_stream_packer.sv
// Byte stream packer: gathers a valid/ready byte stream into REPLICATION_FACTOR-byte
// words. Lane 0 holds the first byte of a word. A frame's short final word is padded
// with PAD_BYTE, and out_keep marks which lanes hold real data. There is one
// accumulator (R-1 lanes plus a lane count) and one output register.
module byte_stream_packer #(
  parameter int unsigned REPLICATION_FACTOR = 3,
  parameter logic [7:0]  PAD_BYTE           = 8'h00
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  output logic [8*REPLICATION_FACTOR-1:0] out_data,
  output logic [REPLICATION_FACTOR-1:0]   out_keep,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last
);

  localparam int unsigned R        = REPLICATION_FACTOR;
  localparam int unsigned CntW     = (R > 1) ? $clog2(R) : 1;
  // With R == 1 no lanes are ever buffered. One dummy lane keeps the vectors legal.
  localparam int unsigned AccLanes = (R > 1) ? R - 1 : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(R - 1);

  logic [CntW-1:0]       count_q, count_d;
  logic [8*AccLanes-1:0] acc_q, acc_d;
  logic [8*R-1:0]        data_q, data_d;
  logic [R-1:0]          keep_q, keep_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;

  logic                  accept;
  logic                  complete;
  logic                  consume;
  logic [8*R-1:0]        word;
  logic [R-1:0]          word_keep;

  // The output slot is free when it is empty or is being drained on this edge.
  assign in_ready = enable & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign complete = accept & (in_last | (count_q == LastCnt));
  assign consume  = enable & valid_q & out_ready;

  // Build the word to emit: buffered lanes, then the incoming byte, then padding.
  always_comb begin
    word      = '0;
    word_keep = '0;
    for (int unsigned k = 0; k < R; k++) begin
      word[8*k +: 8] = PAD_BYTE;
      if (CntW'(k) < count_q) begin
        word[8*k +: 8] = acc_q[8*((k < AccLanes) ? k : 0) +: 8];
      end else if (CntW'(k) == count_q) begin
        word[8*k +: 8] = in_data;
      end
      word_keep[k] = (CntW'(k) <= count_q);
    end
  end

  // Next state: store a byte in the accumulator, or load a finished word, or drain.
  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (complete) begin
      data_d  = word;
      keep_d  = word_keep;
      last_d  = in_last;
      valid_d = 1'b1;
      acc_d   = {AccLanes{PAD_BYTE}};
      count_d = '0;
    end else begin
      if (accept) begin
        for (int unsigned k = 0; k < AccLanes; k++) begin
          if (CntW'(k) == count_q) begin
            acc_d[8*k +: 8] = in_data;
          end
        end
        count_d = count_q + CntW'(1);
      end
      // A drained output keeps its data, keep and last values. Only valid drops.
      if (consume) begin
        valid_d = 1'b0;
      end
    end
  end

  // State register with synchronous reset. A reset discards any partial word.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      acc_q   <= {AccLanes{PAD_BYTE}};
      data_q  <= {R{PAD_BYTE}};
      keep_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_byte_stream_packer.sv
// Testbench for byte_stream_packer with R=3 and PAD=00. It runs a directed vector
// table, hand-written multi-cycle sequences, and random traffic. A queue-based frame
// model in the bench supplies the expected values for the sequences and the random run.
module tb_byte_stream_packer;

  localparam int unsigned R = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [8*R-1:0] out_data;
  logic [R-1:0]  out_keep;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  byte_stream_packer #(
    .REPLICATION_FACTOR(R),
    .PAD_BYTE(8'h00)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_last(in_last),
    .out_data(out_data),
    .out_keep(out_keep),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bytes of the word being collected, plus the output slot.
  logic [7:0]     cur[$];
  logic           m_ov;
  logic [8*R-1:0] m_word;
  logic [R-1:0]   m_keep;
  logic           m_last;
  logic           last_rdy;

  typedef struct {
    logic [7:0]  d;
    logic        v, l, r, e;
    logic        x_rdy, x_ov;
    logic [23:0] x_data;
    logic [2:0]  x_keep;
    logic        x_last;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " out_valid"}, 64'(out_valid), 64'(m_ov));
    check({tag, " out_data"}, 64'(out_data), 64'(m_word));
    check({tag, " out_keep"}, 64'(out_keep), 64'(m_keep));
    check({tag, " out_last"}, 64'(out_last), 64'(m_last));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cur.delete();
    m_ov = 1'b0;
    m_word = '0;
    m_keep = '0;
    m_last = 1'b0;
    check_outputs("reset");
  endtask

  // Runs one clock cycle. The model predicts the word from the frame's bytes in order.
  task automatic cyc(input logic [7:0] d, input logic v, input logic l, input logic r,
                     input logic e);
    logic exp_rdy;
    in_data = d; in_valid = v; in_last = l; out_ready = r; enable = e;
    #3;
    exp_rdy = e & (!m_ov | r);
    last_rdy = in_ready;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (e) begin
      if (v && exp_rdy) begin
        cur.push_back(d);
        if (cur.size() == R || l) begin
          m_word = '0;
          foreach (cur[i]) m_word[8*i +: 8] = cur[i];
          m_keep = R'((1 << cur.size()) - 1);
          m_last = l;
          m_ov = 1'b1;
          cur.delete();
        end else if (m_ov && r) begin
          m_ov = 1'b0;
        end
      end else if (m_ov && r) begin
        m_ov = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    check_outputs("model");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int words, drops;
    tbl[0]  = '{8'h11, 1, 0, 1, 1, 1, 0, 24'h000000, 3'b000, 0};
    tbl[1]  = '{8'h22, 1, 0, 1, 1, 1, 0, 24'h000000, 3'b000, 0};
    tbl[2]  = '{8'h33, 1, 1, 1, 1, 1, 1, 24'h332211, 3'b111, 1};
    tbl[3]  = '{8'hA1, 1, 0, 1, 1, 1, 0, 24'h332211, 3'b111, 1};
    tbl[4]  = '{8'hA2, 1, 0, 1, 1, 1, 0, 24'h332211, 3'b111, 1};
    tbl[5]  = '{8'hA3, 1, 0, 1, 1, 1, 1, 24'hA3A2A1, 3'b111, 0};
    tbl[6]  = '{8'hA4, 1, 0, 1, 1, 1, 0, 24'hA3A2A1, 3'b111, 0};
    tbl[7]  = '{8'hA5, 1, 1, 1, 1, 1, 1, 24'h00A5A4, 3'b011, 1};
    tbl[8]  = '{8'h5C, 1, 1, 1, 1, 1, 1, 24'h00005C, 3'b001, 1};
    tbl[9]  = '{8'h01, 1, 0, 1, 1, 1, 0, 24'h00005C, 3'b001, 1};
    tbl[10] = '{8'h02, 1, 0, 1, 1, 1, 0, 24'h00005C, 3'b001, 1};
    tbl[11] = '{8'h03, 1, 1, 1, 1, 1, 1, 24'h030201, 3'b111, 1};
    tbl[12] = '{8'h00, 0, 0, 1, 1, 1, 0, 24'h030201, 3'b111, 1};
    tbl[13] = '{8'h44, 1, 0, 1, 0, 0, 0, 24'h030201, 3'b111, 1};

    enable = 1'b1; out_ready = 1'b1; in_data = '0;
    do_reset();

    // Directed table: expected values are written out by hand.
    for (int i = 0; i < 14; i++) begin
      in_data = tbl[i].d; in_valid = tbl[i].v; in_last = tbl[i].l;
      out_ready = tbl[i].r; enable = tbl[i].e;
      #3;
      check($sformatf("tbl%0d in_ready", i), 64'(in_ready), 64'(tbl[i].x_rdy));
      @(posedge clock);
      #1;
      check($sformatf("tbl%0d out_valid", i), 64'(out_valid), 64'(tbl[i].x_ov));
      check($sformatf("tbl%0d out_data", i), 64'(out_data), 64'(tbl[i].x_data));
      check($sformatf("tbl%0d out_keep", i), 64'(out_keep), 64'(tbl[i].x_keep));
      check($sformatf("tbl%0d out_last", i), 64'(out_last), 64'(tbl[i].x_last));
    end

    // Backpressure: the held word stays stable, then the next word arrives complete.
    do_reset();
    cyc(8'hB1, 1, 0, 0, 1);
    cyc(8'hB2, 1, 0, 0, 1);
    cyc(8'hB3, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(8'hB4, 1, 0, 0, 1);
      check("bp in_ready", 64'(last_rdy), 64'(0));
      check("bp hold", 64'(out_data), 64'h00B3B2B1);
    end
    cyc(8'hB4, 1, 0, 1, 1);
    cyc(8'hB5, 1, 0, 1, 1);
    cyc(8'hB6, 1, 1, 1, 1);
    check("bp next word", 64'(out_data), 64'h00B6B5B4);
    check("bp next keep", 64'(out_keep), 64'h7);
    check("bp next valid", 64'(out_valid), 64'h1);

    // Continuous stream of 30 bytes, one per cycle.
    do_reset();
    words = 0;
    drops = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(8'(i + 1), 1, (i == 29), 1, 1);
      if (!last_rdy) drops++;
      if (out_valid) words++;
    end
    check("stream words", 64'(words), 64'd10);
    check("stream drops", 64'(drops), 64'd0);
    check("stream final", 64'(out_data), 64'h001E1D1C);
    check("stream final last", 64'(out_last), 64'h1);

    // Reset in the middle of a word.
    do_reset();
    cyc(8'hC1, 1, 0, 1, 1);
    cyc(8'hC2, 1, 0, 1, 1);
    do_reset();
    cyc(8'hD1, 1, 0, 1, 1);
    cyc(8'hD2, 1, 0, 1, 1);
    cyc(8'hD3, 1, 1, 1, 1);
    check("post-reset word", 64'(out_data), 64'h00D3D2D1);
    check("post-reset keep", 64'(out_keep), 64'h7);

    // Freeze in the middle of a frame, and freeze while a word is held.
    cyc(8'hE1, 1, 0, 1, 1);
    cyc(8'hE2, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(8'hEE, 1, 1, 1, 0);
      check("freeze no emit", 64'(out_valid), 64'h0);
    end
    cyc(8'hE3, 1, 1, 1, 1);
    check("resume word", 64'(out_data), 64'h00E3E2E1);
    check("resume last", 64'(out_last), 64'h1);
    for (int i = 0; i < 2; i++) begin
      cyc(8'h00, 0, 0, 1, 0);
      check("freeze hold valid", 64'(out_valid), 64'h1);
    end
    cyc(8'h00, 0, 0, 1, 1);

    // Random traffic, checked against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cyc(8'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
